// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Purpose  : Bit-serial N-bit adder/subtractor. A single 1-bit full-adder
//            cell plus a carry flip-flop processes the operands LSB-first,
//            one bit per clock, and returns a parallel registered result.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled only while ready=1
//            ready  - idle and able to accept an operation
//            a, b   - operands, captured on acceptance
//            sub    - 0: A+B, 1: A-B (captured on acceptance)
//            sum    - registered result, held until the next done
//            co     - final carry-out (for subtraction: 1 = no borrow)
//            ovf    - signed two's-complement overflow
//            done   - one-cycle pulse marking new sum/co/ovf
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 1-bit full-adder cell shared by the serial datapath.
// ----------------------------------------------------------------------------
module serial_addsub_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ ci;
  assign c = (x & y) | (x & ci) | (y & ci);

endmodule

// ----------------------------------------------------------------------------
// Serial adder/subtractor top.
// ----------------------------------------------------------------------------
module serial_addsub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf,
  output logic         done
);

  localparam int            CW     = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Operand shift registers, result shift register and serial carry.
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  // Output registers, kept apart from the working registers so the last
  // result stays visible while a new operation is in flight.
  logic [N-1:0]  r_sum;
  logic          r_co;
  logic          r_ovf;

  logic          w_s;
  logic          w_c;
  logic          w_accept;
  logic          w_last;

  // --------------------------------------------------------------------------
  // Full-adder cell on the current LSBs.
  // --------------------------------------------------------------------------
  serial_addsub_fa u_fa (
    .x  (r_sa[0]),
    .y  (r_sb[0]),
    .ci (r_carry),
    .s  (w_s),
    .c  (w_c)
  );

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == C_LAST);

  // --------------------------------------------------------------------------
  // FSM state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and decoded outputs. ready and done decode directly from
  // the state register, so reset drives them to their idle values at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == C_LAST) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial datapath.
  // Subtraction is A + ~B + 1: B is inverted on load and the carry is seeded
  // with sub.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_sa    <= {1'b0, r_sa[N-1:1]};
      r_sb    <= {1'b0, r_sb[N-1:1]};
      r_res   <= {w_s, r_res[N-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + C_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers, loaded on the edge that processes the MSB (entering
  // DONE). At that edge r_carry still holds the carry into the MSB, so the
  // overflow is that carry-in XOR the final carry-out.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_sum <= {w_s, r_res[N-1:1]};
      r_co  <= w_c;
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign sum = r_sum;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Purpose  : Self-checking bench for serial_addsub (N=8): a table of directed
//            add/subtract vectors plus hand-written sequences for reset,
//            busy protection and back-to-back throughput.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;
  logic         done;

  int tests_run;
  int tests_failed;

  serial_addsub #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vsub;
    logic [7:0] es;
    logic       eco;
    logic       eovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and check latency, hold behaviour and results.
  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tsub, input logic [7:0] es, input logic eco,
                        input logic eovf);
    int          j;
    logic [7:0]  held;
    logic        hold_ok;
    int          wt;
    wt = 0;
    while (!ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    check({name, "_ready_wait"}, 32'(ready), 32'd1);
    a     = ta;
    b     = tb_;
    sub   = tsub;
    start = 1'b1;
    @(negedge clk);          // edge E0 accepted the request
    start = 1'b0;
    held    = sum;
    hold_ok = 1'b1;
    j       = 0;
    while (!done && j < N + 5) begin
      if (sum !== held || ready !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
      j++;
    end
    check({name, "_latency"}, 32'(j), 32'(N));
    check({name, "_hold"}, 32'(hold_ok), 32'd1);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_co"}, 32'(co), 32'(eco));
    check({name, "_ovf"}, 32'(ovf), 32'(eovf));
    check({name, "_ready_in_done"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_ready_back"}, 32'(ready), 32'd1);
    check({name, "_sum_kept"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int   k;
    int   ndone;
    logic bad;

    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
             vecs[i].es, vecs[i].eco, vecs[i].eovf);
    end

    // Busy protection: extra starts and operand/sub changes during BUSY.
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    ndone = 0;
    bad   = 1'b0;
    for (int c = 0; c < N + 6; c++) begin
      if (c < 4) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = ~sub;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        check("busy_sum", 32'(sum), 32'h30);
        check("busy_co", 32'(co), 32'd0);
        check("busy_ovf", 32'(ovf), 32'd0);
      end else if (c < N && sum !== 8'h80) begin
        bad = 1'b1;   // previous result (vec9) must stay put during BUSY
      end
      if (done && ready) bad = 1'b1;
      @(negedge clk);
    end
    check("busy_done_count", 32'(ndone), 32'd1);
    check("busy_sum_stable", 32'(bad), 32'd0);

    // Reset mid-operation.
    a = 8'h3C; b = 8'h5A; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_sum_after", 32'(sum), 32'd0);
    run_op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Throughput: start held high, next op begins on first ready cycle.
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("thru_first_done", 32'(done), 32'd1);
    check("thru_first_sum", 32'(sum), 32'h02);
    a = 8'h20; b = 8'h03;
    @(negedge clk);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("thru_period", 32'(k), 32'(N + 2));
    check("thru_second_sum", 32'(sum), 32'h23);
    repeat (N + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
